// File: rtl/any1_pkg.sv
// Shared ANY-1 types: instruction/value formats, branch opcodes and the
// branch-resolver queue entry and FSM state.
package any1_pkg;

    localparam int BRQ_AMSB = 31;
    localparam int BRQ_TAGW = 4;
    localparam int VAL_W    = 32;

    localparam logic [6:0] OP_BEQ  = 7'h20;
    localparam logic [6:0] OP_BNE  = 7'h21;
    localparam logic [6:0] OP_BLT  = 7'h22;
    localparam logic [6:0] OP_BGE  = 7'h23;
    localparam logic [6:0] OP_BLTU = 7'h24;
    localparam logic [6:0] OP_BGEU = 7'h25;

    typedef struct packed {
        logic [24:0] fields;
        logic [6:0]  opcode;
    } Instruction;

    typedef struct packed {
        logic [3:0]       flags;
        logic [VAL_W-1:0] val;
    } Value;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } BrrState;

    typedef struct packed {
        logic                valid;
        logic                rdy;
        Instruction          inst;
        logic [BRQ_AMSB:0]   pc;
        logic [BRQ_AMSB:0]   tgt;
        logic                pred;
        logic [BRQ_TAGW-1:0] tag;
        Value                a;
        Value                b;
    } BrqEntry;

endpackage

// File: rtl/any1_eval_branch.sv
// Branch comparator: decides taken/not-taken from opcode and the operand values.
module any1_eval_branch
    import any1_pkg::*;
(
    input  Instruction inst,
    input  Value       a,
    input  Value       b,
    output logic       takb
);

    logic unused_ok_s;

    assign unused_ok_s = ^{inst.fields, a.flags, b.flags};

    // Compare only the value payloads; unknown opcodes never branch.
    always_comb begin
        takb = 1'b0;
        case (inst.opcode)
            OP_BEQ:  takb = (a.val == b.val);
            OP_BNE:  takb = (a.val != b.val);
            OP_BLT:  takb = ($signed(a.val) <  $signed(b.val));
            OP_BGE:  takb = ($signed(a.val) >= $signed(b.val));
            OP_BLTU: takb = (a.val <  b.val);
            OP_BGEU: takb = (a.val >= b.val);
            default: takb = 1'b0;
        endcase
    end

endmodule

// File: rtl/any1_branch_resolver.sv
// In-order branch resolution queue: captures operands by tag and resolves the
// head entry through one comparator, reporting over a valid/ready handshake.
module any1_branch_resolver
    import any1_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int AMSB   = BRQ_AMSB,
    parameter int ILEN   = 4,
    parameter int TAGW   = BRQ_TAGW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            enq_valid_i,
    output logic            enq_ready_o,
    input  Instruction      enq_inst_i,
    input  logic [AMSB:0]   enq_pc_i,
    input  logic [AMSB:0]   enq_tgt_i,
    input  logic            enq_pred_i,
    input  logic [TAGW-1:0] enq_tag_i,
    input  logic            opnd_valid_i,
    input  logic [TAGW-1:0] opnd_tag_i,
    input  Value            opnd_a_i,
    input  Value            opnd_b_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [TAGW-1:0] res_tag_o,
    output logic            res_takb_o,
    output logic            res_mispred_o,
    output logic [AMSB:0]   res_redirect_o
);

    localparam int            PW     = $clog2(QDEPTH);
    localparam logic [PW:0]   FULL   = (PW+1)'(QDEPTH);
    localparam logic [AMSB:0] ILEN_A = (AMSB+1)'(ILEN);

    BrqEntry         queue_r [QDEPTH];
    logic [PW-1:0]   head_r, tail_r;
    logic [PW:0]     count_r, count_s;
    BrrState         state_r;
    logic            enq_ready_r, res_valid_r, res_takb_r, res_mispred_r;
    logic [TAGW-1:0] res_tag_r;
    logic [AMSB:0]   res_redirect_r;
    logic            do_enq_s, do_pop_s, enq_match_s, takb_s;
    BrqEntry         head_s, new_entry_s;
    logic            unused_ok_s;

    assign do_enq_s    = enq_valid_i & enq_ready_r;
    assign do_pop_s    = (state_r == RESP) & res_ready_i;
    assign head_s      = queue_r[head_r];
    assign enq_match_s = opnd_valid_i & (opnd_tag_i == enq_tag_i);
    assign unused_ok_s = head_s.valid;

    any1_eval_branch u_eval (
        .inst (head_s.inst),
        .a    (head_s.a),
        .b    (head_s.b),
        .takb (takb_s)
    );

    // Occupancy after this cycle's enqueue/pop.
    always_comb begin
        count_s = count_r;
        case ({do_enq_s, do_pop_s})
            2'b10:   count_s = count_r + (PW+1)'(1);
            2'b01:   count_s = count_r - (PW+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Entry written at the tail; operands arriving in the same cycle are folded in.
    always_comb begin
        new_entry_s       = '0;
        new_entry_s.valid = 1'b1;
        new_entry_s.rdy   = enq_match_s;
        new_entry_s.inst  = enq_inst_i;
        new_entry_s.pc    = enq_pc_i;
        new_entry_s.tgt   = enq_tgt_i;
        new_entry_s.pred  = enq_pred_i;
        new_entry_s.tag   = enq_tag_i;
        if (enq_match_s) begin
            new_entry_s.a = opnd_a_i;
            new_entry_s.b = opnd_b_i;
        end else begin
            new_entry_s.a = '0;
            new_entry_s.b = '0;
        end
    end

    // Queue storage, operand capture by tag and pointer/count bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue_r[i] <= '0;
            end
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            enq_ready_r <= 1'b1;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (queue_r[i].valid && opnd_valid_i && (queue_r[i].tag == opnd_tag_i)) begin
                    queue_r[i].a   <= opnd_a_i;
                    queue_r[i].b   <= opnd_b_i;
                    queue_r[i].rdy <= 1'b1;
                end
            end
            if (do_pop_s) begin
                queue_r[head_r].valid <= 1'b0;
                head_r                <= head_r + PW'(1);
            end
            if (do_enq_s) begin
                queue_r[tail_r] <= new_entry_s;
                tail_r          <= tail_r + PW'(1);
            end
            count_r     <= count_s;
            enq_ready_r <= (count_s < FULL);
        end
    end

    // Resolution FSM; the result registers stay frozen while RESP waits for ready.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_r        <= IDLE;
            res_valid_r    <= 1'b0;
            res_tag_r      <= '0;
            res_takb_r     <= 1'b0;
            res_mispred_r  <= 1'b0;
            res_redirect_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_s != '0) state_r <= WAIT;
                end
                WAIT: begin
                    if (head_s.rdy) begin
                        res_valid_r    <= 1'b1;
                        res_tag_r      <= head_s.tag;
                        res_takb_r     <= takb_s;
                        res_mispred_r  <= takb_s ^ head_s.pred;
                        res_redirect_r <= takb_s ? head_s.tgt : (head_s.pc + ILEN_A);
                        state_r        <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready_i) begin
                        res_valid_r <= 1'b0;
                        state_r     <= (count_s != '0) ? WAIT : IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign enq_ready_o    = enq_ready_r;
    assign res_valid_o    = res_valid_r;
    assign res_tag_o      = res_tag_r;
    assign res_takb_o     = res_takb_r;
    assign res_mispred_o  = res_mispred_r;
    assign res_redirect_o = res_redirect_r;

endmodule

// File: tb/tb_any1_branch_resolver.sv
// Scoreboard bench for any1_branch_resolver: directed scenarios followed by
// randomized traffic checked against a program-order reference model.
module tb_any1_branch_resolver;
    import any1_pkg::*;

    localparam logic [6:0] OP_OTHER = 7'h33;

    logic       clk = 1'b0;
    logic       rst_i, flush_i, enq_valid_i, enq_ready_o, enq_pred_i;
    logic       opnd_valid_i, res_valid_o, res_ready_i, res_takb_o, res_mispred_o;
    Instruction enq_inst_i;
    logic [31:0] enq_pc_i, enq_tgt_i, res_redirect_o;
    logic [3:0]  enq_tag_i, opnd_tag_i, res_tag_o;
    Value        opnd_a_i, opnd_b_i;

    typedef struct { logic [3:0] tag; logic takb; logic mispred; logic [31:0] redirect; } exp_t;
    typedef struct { logic [3:0] tag; logic [31:0] a; logic [31:0] b; } opnd_t;

    exp_t  exp_q[$];
    opnd_t pend_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;
    logic  hold_v = 1'b0;
    exp_t  held;

    always #5 clk = ~clk;

    any1_branch_resolver dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_inst_i(enq_inst_i),
        .enq_pc_i(enq_pc_i), .enq_tgt_i(enq_tgt_i), .enq_pred_i(enq_pred_i), .enq_tag_i(enq_tag_i),
        .opnd_valid_i(opnd_valid_i), .opnd_tag_i(opnd_tag_i), .opnd_a_i(opnd_a_i), .opnd_b_i(opnd_b_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_tag_o(res_tag_o),
        .res_takb_o(res_takb_o), .res_mispred_o(res_mispred_o), .res_redirect_o(res_redirect_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: what the branch does architecturally, independent of queueing.
    function automatic exp_t model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] tgt,
                                   input logic pred, input logic [3:0] tag);
        exp_t e;
        logic t;
        case (op)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) < $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a < b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        e.tag      = tag;
        e.takb     = t;
        e.mispred  = (t != pred);
        e.redirect = t ? tgt : pc + 32'd4;
        return e;
    endfunction

    function automatic logic tag_busy(input logic [3:0] t);
        foreach (exp_q[i]) if (exp_q[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] free_tag();
        logic [3:0] t;
        for (int k = 0; k < 64; k++) begin
            t = 4'($urandom);
            if (!tag_busy(t)) return t;
        end
        for (int k = 0; k < 16; k++) if (!tag_busy(4'(k))) return 4'(k);
        return 4'd0;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2:       return 32'h8000_0000 + 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] ops [7];
        ops = '{OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_OTHER};
        return ops[$urandom_range(0, 6)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid_i  = 1'b0;
        opnd_valid_i = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic deliver(input opnd_t o);
        opnd_valid_i = 1'b1;
        opnd_tag_i   = o.tag;
        opnd_a_i     = {4'($urandom), o.a};
        opnd_b_i     = {4'($urandom), o.b};
    endtask

    task automatic deliver_tag(input logic [3:0] t);
        foreach (pend_q[i]) begin
            if (pend_q[i].tag == t) begin
                deliver(pend_q[i]);
                pend_q.delete(i);
                return;
            end
        end
    endtask

    task automatic drive_enq(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                             input logic [3:0] tag, input logic with_opnd);
        opnd_t o;
        enq_valid_i = 1'b1;
        enq_inst_i  = {25'($urandom), op};
        enq_pc_i    = pc;
        enq_tgt_i   = tgt;
        enq_pred_i  = pred;
        enq_tag_i   = tag;
        o.tag = tag;
        o.a   = a;
        o.b   = b;
        if (with_opnd) deliver(o);
        if (enq_ready_o && !flush_i) begin
            exp_q.push_back(model(op, a, b, pc, tgt, pred, tag));
            if (!with_opnd) pend_q.push_back(o);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        res_ready_i = 1'b1;
        while ((exp_q.size() != 0 || res_valid_o) && n < 200) begin
            tick();
            idle_inputs();
            if (pend_q.size() != 0) deliver(pend_q.pop_front());
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        idle_inputs();
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (flush_i) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid",    32'(res_valid_o),   32'd1);
                    check("hold_tag",      32'(res_tag_o),     32'(held.tag));
                    check("hold_takb",     32'(res_takb_o),    32'(held.takb));
                    check("hold_mispred",  32'(res_mispred_o), 32'(held.mispred));
                    check("hold_redirect", res_redirect_o,     held.redirect);
                end
                if (res_valid_o && res_ready_i) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("spurious_result", 32'(res_valid_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_tag",      32'(res_tag_o),     32'(e.tag));
                        check("res_takb",     32'(res_takb_o),    32'(e.takb));
                        check("res_mispred",  32'(res_mispred_o), 32'(e.mispred));
                        check("res_redirect", res_redirect_o,     e.redirect);
                    end
                end else if (res_valid_o) begin
                    hold_v        = 1'b1;
                    held.tag      = res_tag_o;
                    held.takb     = res_takb_o;
                    held.mispred  = res_mispred_o;
                    held.redirect = res_redirect_o;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        idle_inputs();
        res_ready_i = 1'b0;
        enq_inst_i  = '0;
        enq_pc_i    = '0;
        enq_tgt_i   = '0;
        enq_pred_i  = 1'b0;
        enq_tag_i   = '0;
        opnd_tag_i  = '0;
        opnd_a_i    = '0;
        opnd_b_i    = '0;
        repeat (3) tick();
        check("rst_enq_ready", 32'(enq_ready_o),   32'd1);
        check("rst_res_valid", 32'(res_valid_o),   32'd0);
        check("rst_res_tag",   32'(res_tag_o),     32'd0);
        check("rst_takb",      32'(res_takb_o),    32'd0);
        check("rst_mispred",   32'(res_mispred_o), 32'd0);
        check("rst_redirect",  res_redirect_o,     32'd0);
        rst_i       = 1'b0;
        mon_en      = 1'b1;
        res_ready_i = 1'b1;

        // Minimum latency with operands arriving alongside the enqueue.
        tick();
        drive_enq(OP_BEQ, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0, 4'd1, 1'b1);
        tick();
        idle_inputs();
        check("lat_t1_valid", 32'(res_valid_o), 32'd0);
        tick();
        check("lat_t2_valid", 32'(res_valid_o),   32'd1);
        check("beq_takb",     32'(res_takb_o),    32'd1);
        check("beq_mispred",  32'(res_mispred_o), 32'd1);
        check("beq_redirect", res_redirect_o,     32'h200);
        drain("drain_beq");

        // Signed versus unsigned compare of the same operands.
        tick();
        drive_enq(OP_BLT,  32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h2000, 1'b0, 4'd2, 1'b1);
        tick();
        drive_enq(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h1010, 32'h3000, 1'b1, 4'd3, 1'b1);
        tick();
        idle_inputs();
        drain("drain_signed");

        // Younger ready entry must wait for the older one.
        tick();
        drive_enq(OP_BNE, 32'd1, 32'd2, 32'h40, 32'h80, 1'b0, 4'd1, 1'b0);
        tick();
        drive_enq(OP_BGE, 32'd7, 32'd3, 32'h44, 32'h90, 1'b0, 4'd2, 1'b0);
        tick();
        idle_inputs();
        deliver_tag(4'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            check("order_wait", 32'(res_valid_o), 32'd0);
        end
        deliver_tag(4'd1);
        drain("drain_order");

        // Fill, reject a fifth, pop one, stall, then flush mid-response.
        res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_enq(OP_BEQ, 32'(i), 32'(i), 32'h400 + 32'(16 * i), 32'h800, 1'b1, 4'(i + 3), 1'b0);
        end
        tick();
        idle_inputs();
        check("full_ready", 32'(enq_ready_o), 32'd0);
        drive_enq(OP_BNE, 32'd1, 32'd2, 32'h500, 32'h900, 1'b0, 4'd9, 1'b1);
        tick();
        idle_inputs();
        check("full_ready_hold", 32'(enq_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            deliver(pend_q.pop_front());
            tick();
            idle_inputs();
        end
        repeat (5) tick();
        check("stall_valid", 32'(res_valid_o), 32'd1);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("ready_after_pop", 32'(enq_ready_o), 32'd1);
        repeat (6) tick();
        check("stall2_valid", 32'(res_valid_o), 32'd1);
        flush_i = 1'b1;
        exp_q.delete();
        pend_q.delete();
        tick();
        flush_i = 1'b0;
        check("flush_valid",     32'(res_valid_o), 32'd0);
        check("flush_enq_ready", 32'(enq_ready_o), 32'd1);
        check("flush_tag",       32'(res_tag_o),   32'd0);
        check("flush_redirect",  res_redirect_o,   32'd0);
        res_ready_i = 1'b1;

        // Non-branch opcode with a taken prediction.
        tick();
        drive_enq(OP_OTHER, 32'd9, 32'd9, 32'h7FC, 32'hABC, 1'b1, 4'd5, 1'b1);
        tick();
        idle_inputs();
        drain("drain_nonbranch");

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       used;
            logic [3:0] t;
            logic [31:0] a, b;
            opnd_t      o;
            tick();
            idle_inputs();
            used = 1'b0;
            check("enq_ready", 32'(enq_ready_o), 32'(exp_q.size() < 4));
            res_ready_i = ($urandom_range(0, 9) < 7);
            a = rand_val();
            b = ($urandom_range(0, 9) < 3) ? a : rand_val();
            if ($urandom_range(0, 249) == 0) begin
                flush_i = 1'b1;
                exp_q.delete();
                pend_q.delete();
                drive_enq(rand_op(), a, b, $urandom, $urandom, 1'($urandom), free_tag(), 1'b1);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    t    = free_tag();
                    used = ($urandom_range(0, 3) == 0);
                    drive_enq(rand_op(), a, b,
                              ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                              $urandom, 1'($urandom), t, used);
                end
                if (!used) begin
                    if (pend_q.size() != 0 && $urandom_range(0, 9) < 6) begin
                        int idx;
                        idx = $urandom_range(0, pend_q.size() - 1);
                        deliver(pend_q[idx]);
                        pend_q.delete(idx);
                    end else if ($urandom_range(0, 9) == 0) begin
                        t = free_tag();
                        if (!(enq_valid_i && t == enq_tag_i)) begin
                            o.tag = t;
                            o.a   = a;
                            o.b   = b;
                            deliver(o);
                        end
                    end
                end
            end
        end
        tick();
        idle_inputs();
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
